// File: rtl/host_bus_pkg.sv
// -----------------------------------------------------------------------------
// host_bus_pkg
//   Shared definitions for the M1 host-bus initiator: bus widths, phase
//   counter width, FSM state encoding, and the register map of the FPGA
//   register slave so benches and host-emulation logic use one set of
//   addresses.
//   No ports (package).
// -----------------------------------------------------------------------------
package host_bus_pkg;

   localparam int ADDR_W = 21;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      TURN
   } bm_state_t;

   // Slave register map
   localparam logic [ADDR_W-1:0] ADDR_CLCD     = 21'h00010;
   localparam logic [ADDR_W-1:0] ADDR_LED_CTRL = 21'h00020;
   localparam logic [ADDR_W-1:0] ADDR_DIP      = 21'h00022;
   localparam logic [ADDR_W-1:0] ADDR_SEG_CMD0 = 21'h00030;
   localparam logic [ADDR_W-1:0] ADDR_SEG_CMD1 = 21'h00031;
   localparam logic [ADDR_W-1:0] ADDR_SEG_DAT0 = 21'h00032;
   localparam logic [ADDR_W-1:0] ADDR_SEG_DAT1 = 21'h00033;
   localparam logic [ADDR_W-1:0] ADDR_SEG_RB0  = 21'h00034;
   localparam logic [ADDR_W-1:0] ADDR_SEG_RB1  = 21'h00036;
   localparam logic [ADDR_W-1:0] ADDR_DOT0     = 21'h00040;
   localparam logic [ADDR_W-1:0] ADDR_DOT1     = 21'h00042;
   localparam logic [ADDR_W-1:0] ADDR_PIEZO    = 21'h00050;
   localparam logic [ADDR_W-1:0] ADDR_PUSH0    = 21'h00070;
   localparam logic [ADDR_W-1:0] ADDR_PUSH1    = 21'h00072;
   localparam logic [ADDR_W-1:0] ADDR_PUSH_SW  = 21'h00080;
   localparam logic [ADDR_W-1:0] ADDR_ID       = 21'h00092;
   localparam logic [ADDR_W-1:0] ADDR_HOST_SEL = 21'h000F0;

   localparam logic [DATA_W-1:0] ID_VALUE = 16'h002A;

   // Counter load value for a phase lasting 'cyc' clocks (counts down to 0).
   function automatic logic [CNT_W-1:0] phase_len(input int cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/host_bus_master_if.sv
// -----------------------------------------------------------------------------
// host_bus_master_if
//   Request/response handshake plus the physical host-bus strobes.
//   master modport : the initiator (host_bus_master)
//   slave  modport : the environment (requester + register slave)
//   Signals: req_valid/req_ready/req_write/req_addr/req_wdata,
//            rsp_valid/rsp_rdata/busy,
//            HOST_nCS/HOST_nWE/HOST_nOE/HOST_ADD/HDI (to slave), HDO (from slave)
// -----------------------------------------------------------------------------
interface host_bus_master_if;
   import host_bus_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              busy;
   logic              HOST_nCS;
   logic              HOST_nWE;
   logic              HOST_nOE;
   logic [ADDR_W-1:0] HOST_ADD;
   logic [DATA_W-1:0] HDI;
   logic [DATA_W-1:0] HDO;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, HDO,
      output req_ready, rsp_valid, rsp_rdata, busy,
             HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, HDO,
      input  req_ready, rsp_valid, rsp_rdata, busy,
             HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI
   );

endinterface

// File: rtl/in_sync_edge.sv
// -----------------------------------------------------------------------------
// in_sync_edge
//   Two-flop synchronizer for an asynchronous level, a delay flop, and a
//   registered rising-edge pulse. A rise on din appears on 'rise' after the
//   3rd clk edge; a held level yields a single pulse.
//   Ports: clk, nRESET (async, active low), din (async level),
//          sync (synchronized level), rise (one-cycle pulse)
//   RST_VAL: reset level of the synchronizer chain (1 for active-low inputs).
// -----------------------------------------------------------------------------
module in_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic nRESET,
   input  logic din,
   output logic sync,
   output logic rise
);

   logic meta;
   logic dly;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         meta <= RST_VAL;
         sync <= RST_VAL;
         dly  <= RST_VAL;
         rise <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         dly  <= sync;
         rise <= sync & ~dly;
      end
   end

endmodule

// File: rtl/host_bus_master.sv
// -----------------------------------------------------------------------------
// host_bus_master
//   Initiator of the M1 host memory-mapped bus. Turns one valid/ready
//   request into a SETUP / STROBE / HOLD / TURN strobe sequence, captures
//   read data at the end of STROBE, and returns a one-cycle response.
//   Also turns the slave's asynchronous INT level into a one-cycle pulse.
//   Ports: clk, nRESET (async, active low), bus (host_bus_master_if.master),
//          INT (async level in), int_pulse (out), nWAIT (in, optional)
//   Build option: HOST_BM_WAIT_EN adds the active-low nWAIT input, which
//   stretches STROBE while its synchronized level is low.
//   All outputs are registered.
// -----------------------------------------------------------------------------
module host_bus_master
   import host_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              nRESET,
   host_bus_master_if.master bus,
   input  logic              INT,
`ifdef HOST_BM_WAIT_EN
   input  logic              nWAIT,
`endif
   output logic              int_pulse
);

   // STROBE needs >=2 cycles because the slave registers HDO one clock
   // after nOE falls.
   if (SETUP_CYC < 1 || SETUP_CYC > (1 << CNT_W)) begin : g_bad_setup
      $error("SETUP_CYC out of range");
   end
   if (STROBE_CYC < 2 || STROBE_CYC > (1 << CNT_W)) begin : g_bad_strobe
      $error("STROBE_CYC out of range");
   end
   if (HOLD_CYC < 1 || HOLD_CYC > (1 << CNT_W)) begin : g_bad_hold
      $error("HOLD_CYC out of range");
   end

   bm_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              wr_q, wr_nxt;
   logic [DATA_W-1:0] rdata_q;
   logic              accept;
   logic              strobe_done;
   logic              wait_ok;
   logic              in_cycle_nxt;
   logic              ncs_nxt, nwe_nxt, noe_nxt;

   logic              unused_int_lvl;

   in_sync_edge #(.RST_VAL(1'b0)) u_int_sync (
      .clk    (clk),
      .nRESET (nRESET),
      .din    (INT),
      .sync   (unused_int_lvl),
      .rise   (int_pulse)
   );

`ifdef HOST_BM_WAIT_EN
   logic wait_n_sync;
   logic unused_wait_rise;

   in_sync_edge #(.RST_VAL(1'b1)) u_wait_sync (
      .clk    (clk),
      .nRESET (nRESET),
      .din    (nWAIT),
      .sync   (wait_n_sync),
      .rise   (unused_wait_rise)
   );

   assign wait_ok = wait_n_sync;
`else
   assign wait_ok = 1'b1;
`endif

   // req_ready is itself the registered "in IDLE" flag.
   assign accept      = bus.req_valid && bus.req_ready;
   // Last STROBE edge: counter exhausted and the slave not holding the bus.
   assign strobe_done = (state == STROBE) && (cnt == '0) && wait_ok;

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_nxt    = wr_q;

      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SETUP;
               cnt_nxt   = phase_len(SETUP_CYC);
               wr_nxt    = bus.req_write;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nxt = STROBE;
               cnt_nxt   = phase_len(STROBE_CYC);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         STROBE: begin
            if (strobe_done) begin
               state_nxt = HOLD;
               cnt_nxt   = phase_len(HOLD_CYC);
            end else if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nxt = TURN;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         TURN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Outputs are decoded from the next state and registered below, so
      // the pins change on the same edge the FSM enters each phase.
      in_cycle_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) ||
                     (state_nxt == HOLD);
      ncs_nxt      = !in_cycle_nxt;
      nwe_nxt      = !((state_nxt == STROBE) &&  wr_nxt);
      noe_nxt      = !((state_nxt == STROBE) && !wr_nxt);
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state         <= IDLE;
         cnt           <= '0;
         wr_q          <= 1'b0;
         rdata_q       <= '0;
         bus.req_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.HOST_nCS  <= 1'b1;
         bus.HOST_nWE  <= 1'b1;
         bus.HOST_nOE  <= 1'b1;
         bus.HOST_ADD  <= '0;
         bus.HDI       <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         wr_q          <= wr_nxt;
         bus.req_ready <= (state_nxt == IDLE);
         bus.busy      <= in_cycle_nxt;
         bus.rsp_valid <= (state_nxt == TURN);
         bus.HOST_nCS  <= ncs_nxt;
         bus.HOST_nWE  <= nwe_nxt;
         bus.HOST_nOE  <= noe_nxt;

         if (accept) begin
            bus.HOST_ADD <= bus.req_addr;
            bus.HDI      <= bus.req_wdata;
         end

         if (strobe_done && !wr_q) begin
            rdata_q <= bus.HDO;
         end

         if (state_nxt == TURN) begin
            bus.rsp_rdata <= wr_q ? '0 : rdata_q;
         end
      end
   end

endmodule
